// File: rtl/ht_decoder.sv
// ht_decoder: serial Huffman decoder with a loadable 8-entry codebook.
// Optional table validity check enabled by defining HTD_TBL_CHECK_EN.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tbl_valid/len/code    codebook entry write (entries 0..7 in order)
//   in_valid/in_code      MSB-first serial code bits
//   out_valid/char/last   decoded character pulse, index, frame-last flag
//   out_err               no-match (or invalid table) pulse
//   tbl_ready             a complete table is held
module ht_decoder #(
    parameter int N_CHAR = 5,
    parameter int CODE_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tbl_valid,
    input  logic [2:0]        tbl_len,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic              in_valid,
    input  logic              in_code,
    output logic              out_valid,
    output logic [2:0]        out_char,
    output logic              out_last,
    output logic              out_err,
    output logic              tbl_ready
);

    localparam int CNT_W = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY,
        DECODE
    } state_t;

    state_t            state, state_d;
    logic [2:0]        len_q  [8];
    logic [CODE_W-1:0] code_q [8];
    logic [CODE_W-2:0] acc;
    logic [2:0]        acc_len;
    logic [2:0]        ent_q;
    logic [CNT_W-1:0]  char_q;

    logic              wr;
    logic [2:0]        wr_idx;
    logic              proc;
    logic              chk_err;
    logic              bad_q;

    logic [CODE_W-1:0] cand;
    logic [2:0]        cand_len;
    logic [CODE_W-1:0] mask;
    logic              hit;
    logic [2:0]        hit_idx;
    logic              frame_end;
    logic              overflow;

    assign cand      = {acc, in_code};
    assign cand_len  = acc_len + 3'd1;
    assign mask      = ~({CODE_W{1'b1}} << cand_len);
    assign frame_end = (char_q == CNT_W'(N_CHAR - 1));
    assign overflow  = (cand_len == 3'(CODE_W));
    assign tbl_ready = (state == READY) || (state == DECODE);

    // Scan downward so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (len_q[i] == cand_len &&
                ((code_q[i] ^ cand) & mask) == '0) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state;
        wr      = 1'b0;
        wr_idx  = ent_q;
        proc    = 1'b0;
        chk_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (tbl_valid) begin
                    wr      = 1'b1;
                    wr_idx  = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (tbl_valid) begin
                    wr = 1'b1;
                    if (ent_q == 3'd7) state_d = READY;
                end
            end
            READY: begin
                if (tbl_valid) begin
                    wr      = 1'b1;
                    wr_idx  = 3'd0;
                    state_d = LOAD;
                end else if (in_valid) begin
                    if (bad_q) begin
                        chk_err = 1'b1;
                    end else begin
                        proc    = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                proc = in_valid;
            end
            default: state_d = IDLE;
        endcase
        if (proc) begin
            if (hit) begin
                if (frame_end) state_d = READY;
            end else if (overflow) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                len_q[i]  <= '0;
                code_q[i] <= '0;
            end
            acc       <= '0;
            acc_len   <= '0;
            ent_q     <= '0;
            char_q    <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= chk_err;
            if (wr) begin
                len_q[wr_idx]  <= tbl_len;
                code_q[wr_idx] <= tbl_code;
                ent_q          <= wr_idx + 3'd1;
            end
            if (proc) begin
                if (hit) begin
                    out_valid <= 1'b1;
                    out_char  <= hit_idx;
                    acc       <= '0;
                    acc_len   <= '0;
                    if (frame_end) begin
                        out_last <= 1'b1;
                        char_q   <= '0;
                    end else begin
                        char_q <= char_q + CNT_W'(1);
                    end
                end else if (overflow) begin
                    // Longest code seen without a match: abort the frame.
                    out_err <= 1'b1;
                    acc     <= '0;
                    acc_len <= '0;
                    char_q  <= '0;
                end else begin
                    acc     <= cand[CODE_W-2:0];
                    acc_len <= cand_len;
                end
            end
        end
    end

`ifdef HTD_TBL_CHECK_EN
    logic bad_d;

    // Entry 7 is being written this cycle, so take its length from the port.
    always_comb begin
        bad_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (((i == 7) ? tbl_len : len_q[i]) == 3'd0) bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
        end else if (wr) begin
            if (wr_idx == 3'd7)      bad_q <= bad_d;
            else if (wr_idx == 3'd0) bad_q <= 1'b0;
        end
    end
`else
    assign bad_q = 1'b0;
`endif

endmodule

// File: tb/tb_ht_decoder.sv
// tb_ht_decoder: directed tests for the serial Huffman decoder.
// Covers reset, decode, gaps, no-match, reload, mid-frame reset, table check.
module tb_ht_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tbl_valid = 1'b0;
    logic [2:0] tbl_len = '0;
    logic [6:0] tbl_code = '0;
    logic       in_valid = 1'b0;
    logic       in_code = 1'b0;
    logic       out_valid;
    logic [2:0] out_char;
    logic       out_last;
    logic       out_err;
    logic       tbl_ready;

    int errors = 0;
    int checks = 0;

    logic [2:0] t_len  [8];
    logic [6:0] t_code [8];
    logic       ov, ol, oe;
    logic [2:0] oc;

    ht_decoder #(.N_CHAR(5), .CODE_W(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tbl_valid(tbl_valid),
        .tbl_len(tbl_len),
        .tbl_code(tbl_code),
        .in_valid(in_valid),
        .in_code(in_code),
        .out_valid(out_valid),
        .out_char(out_char),
        .out_last(out_last),
        .out_err(out_err),
        .tbl_ready(tbl_ready)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        in_code  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ov = out_valid;
        oc = out_char;
        ol = out_last;
        oe = out_err;
    endtask

    task automatic load(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            tbl_valid = 1'b1;
            tbl_len   = t_len[i];
            tbl_code  = t_code[i];
            @(posedge clk);
            #1;
            tbl_valid = 1'b0;
            if (i == 2) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_table1();
        t_len[0] = 3'd2; t_code[0] = 7'b0000000;
        t_len[1] = 3'd3; t_code[1] = 7'b0000010;
        t_len[2] = 3'd3; t_code[2] = 7'b0000011;
        t_len[3] = 3'd3; t_code[3] = 7'b0000100;
        t_len[4] = 3'd3; t_code[4] = 7'b0000101;
        t_len[5] = 3'd3; t_code[5] = 7'b0000110;
        t_len[6] = 3'd4; t_code[6] = 7'b0001110;
        t_len[7] = 3'd4; t_code[7] = 7'b0001111;
    endtask

    // Codewords separated by spaces; exp holds char k in bits [3k+:3].
    task automatic run_stream(input string nm, input string s,
                              input logic [14:0] exp,
                              input bit last, input bit gaps);
        int k;
        bit fin;
        logic [2:0] ec;
        logic el;
        k = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == " ") continue;
            if (gaps) begin
                int g;
                g = int'($urandom_range(2, 0));
                repeat (g) begin
                    step(1'b0, 1'b0);
                    checks++;
                    if (ov !== 1'b0 || oe !== 1'b0) begin
                        errors++;
                        $display("FAIL %s gap: out_valid=%b out_err=%b want 0 0",
                                 nm, ov, oe);
                    end
                end
            end
            step(1'b1, s[i] == "1");
            fin = (i == s.len() - 1) || (s[i+1] == " ");
            checks++;
            if (fin) begin
                ec = exp[3*k +: 3];
                el = last && (i == s.len() - 1);
                if (ov !== 1'b1 || oc !== ec || ol !== el || oe !== 1'b0) begin
                    errors++;
                    $display("FAIL %s char%0d: v=%b c=%0d l=%b e=%b want 1 %0d %b 0",
                             nm, k, ov, oc, ol, oe, ec, el);
                end
                k++;
            end else if (ov !== 1'b0 || ol !== 1'b0 || oe !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: v=%b l=%b e=%b want 0 0 0",
                         nm, i, ov, ol, oe);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_char !== 3'd0 || out_last !== 1'b0 ||
            out_err !== 1'b0 || tbl_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: v=%b c=%0d l=%b e=%b r=%b want all 0",
                     out_valid, out_char, out_last, out_err, tbl_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (ov !== 1'b0 || oe !== 1'b0 || tbl_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_bits: v=%b e=%b r=%b want 0 0 0", ov, oe, tbl_ready);
        end
    endtask

    task automatic test_back_to_back();
        set_table1();
        load(0, 8);
        checks++;
        if (tbl_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_load: tbl_ready=%b want 1", tbl_ready);
        end
        run_stream("b2b", "101 110 1110 1111 100",
                   {3'd3, 3'd7, 3'd6, 3'd5, 3'd4}, 1'b1, 1'b0);
    endtask

    task automatic test_gaps();
        run_stream("gaps", "101 011 110 00 010",
                   {3'd1, 3'd0, 3'd5, 3'd2, 3'd4}, 1'b1, 1'b1);
    endtask

    task automatic test_no_match();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            t_len[i]  = 3'd7;
            t_code[i] = 7'h7F;
        end
        load(0, 8);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (ov !== 1'b0 || oe !== (i == 6)) begin
                errors++;
                $display("FAIL nomatch bit%0d: v=%b e=%b want 0 %b",
                         i, ov, oe, (i == 6));
            end
        end
        checks++;
        if (tbl_ready !== 1'b1) begin
            errors++;
            $display("FAIL nomatch_ready: tbl_ready=%b want 1", tbl_ready);
        end
        run_stream("ones", "1111111", {12'd0, 3'd0}, 1'b0, 1'b0);
    endtask

    task automatic test_tbl_ignore();
        do_reset();
        set_table1();
        load(0, 8);
        run_stream("pre", "101", {12'd0, 3'd4}, 1'b0, 1'b0);
        @(negedge clk);
        tbl_valid = 1'b1;
        tbl_len   = 3'd2;
        tbl_code  = 7'b0000011;
        @(posedge clk);
        #1;
        tbl_valid = 1'b0;
        run_stream("post", "110 1110 1111 100",
                   {3'd0, 3'd3, 3'd7, 3'd6, 3'd5}, 1'b1, 1'b0);
        t_len[0] = 3'd3; t_code[0] = 7'b0000010;
        t_len[1] = 3'd2; t_code[1] = 7'b0000000;
        load(0, 8);
        run_stream("swap", "00", {12'd0, 3'd1}, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_table1();
        load(0, 8);
        run_stream("mid", "101 110", {9'd0, 3'd5, 3'd4}, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_char !== 3'd0 || out_last !== 1'b0 ||
            out_err !== 1'b0 || tbl_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset: v=%b c=%0d l=%b e=%b r=%b want all 0",
                     out_valid, out_char, out_last, out_err, tbl_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (ov !== 1'b0 || oe !== 1'b0) begin
                errors++;
                $display("FAIL after_reset bit%0d: v=%b e=%b want 0 0", i, ov, oe);
            end
        end
        load(0, 7);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (ov !== 1'b0 || oe !== 1'b0 || tbl_ready !== 1'b0) begin
            errors++;
            $display("FAIL partial_load: v=%b e=%b r=%b want 0 0 0", ov, oe, tbl_ready);
        end
        load(7, 1);
        checks++;
        if (tbl_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_ready: tbl_ready=%b want 1", tbl_ready);
        end
        run_stream("reloaded", "00", {12'd0, 3'd0}, 1'b0, 1'b0);
    endtask

    task automatic test_tbl_check();
        do_reset();
        set_table1();
        t_len[3] = 3'd0;
        load(0, 8);
`ifdef HTD_TBL_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (ov !== 1'b0 || oe !== 1'b1 || tbl_ready !== 1'b1) begin
                errors++;
                $display("FAIL badtbl bit%0d: v=%b e=%b r=%b want 0 1 1",
                         i, ov, oe, tbl_ready);
            end
        end
        set_table1();
        load(0, 8);
        run_stream("goodtbl", "00", {12'd0, 3'd0}, 1'b0, 1'b0);
`else
        run_stream("len0tbl", "00", {12'd0, 3'd0}, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_no_match();
        test_tbl_ignore();
        test_reset_mid();
        test_tbl_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
